// File: rtl/guitar_pkg.sv
// guitar_pkg: shared types and constants for the fret hit judge
package guitar_pkg;
  localparam int LANES_DEF = 5;
  localparam int BASE_GOOD = 1;
  localparam int BASE_PERFECT = 3;
  localparam int MULT_CAP = 4;
  typedef enum logic [1:0] {GRADE_MISS, GRADE_GOOD, GRADE_PERFECT} grade_e;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REPORT} judge_state_e;
endpackage

// File: rtl/lane_edge_detect.sv
// lane_edge_detect: registers fret levels and flags their rising edges
module lane_edge_detect #(
  parameter int LANES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] btn_state,
  output logic [LANES-1:0] btn_q,
  output logic [LANES-1:0] press_edge
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= '0;
      press_edge <= '0;
    end else begin
      btn_q <= btn_state;
      press_edge <= btn_state & ~btn_q;
    end
  end
endmodule

// File: rtl/note_hit_judge.sv
// note_hit_judge: grades fret presses against a note window, keeps score and streak
module note_hit_judge
  import guitar_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WINDOW = 8,
  parameter int PERFECT_W = 2,
  parameter int SCORE_W = 16,
  parameter int STREAK_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [LANES-1:0]    btn_state,
  input  logic                note_valid,
  input  logic [LANES-1:0]    note_mask,
  output logic                note_ready,
  output logic [LANES-1:0]    press_edge,
  output logic                result_valid,
  output logic [1:0]          result_grade,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak
);
  localparam int CW = $clog2(2*WINDOW+1);
  localparam logic [CW-1:0] WIN = CW'(WINDOW);
  localparam logic [CW-1:0] WIN_END = CW'(2*WINDOW);
  localparam logic [CW-1:0] PW = CW'(PERFECT_W);
  judge_state_e state;
  grade_e grade_q;
  logic [LANES-1:0] mask_q, btn_q;
  logic [CW-1:0] win_cnt, offset;
  logic seen_edge, seen_next, wrong, hit;
  logic [STREAK_W-1:0] sh, mult;
  logic [SCORE_W:0] base, sum;
  lane_edge_detect #(.LANES(LANES)) u_edge (
    .clk(clk), .rst_n(rst_n), .btn_state(btn_state), .btn_q(btn_q), .press_edge(press_edge)
  );
  assign note_ready = state == S_IDLE;
  assign result_valid = state == S_REPORT;
  assign result_grade = grade_q;
  always_comb begin
    wrong = |(press_edge & ~mask_q);
    seen_next = seen_edge | (|(press_edge & mask_q));
    hit = seen_next && btn_q == mask_q;
    offset = win_cnt >= WIN ? win_cnt - WIN : WIN - win_cnt;
    sh = streak >> 3;
    mult = sh >= STREAK_W'(MULT_CAP-1) ? STREAK_W'(MULT_CAP) : sh + STREAK_W'(1);
    base = grade_q == GRADE_PERFECT ? (SCORE_W+1)'(BASE_PERFECT) :
           grade_q == GRADE_GOOD ? (SCORE_W+1)'(BASE_GOOD) : '0;
    sum = {1'b0, score} + base * (SCORE_W+1)'(mult);
  end
  // Priority inside a window: wrong lane, then completed hit, then timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grade_q <= GRADE_MISS;
      mask_q <= '0;
      win_cnt <= '0;
      seen_edge <= 1'b0;
      score <= '0;
      streak <= '0;
    end else begin
      case (state)
        S_IDLE: if (note_valid) begin
          mask_q <= note_mask;
          win_cnt <= '0;
          seen_edge <= 1'b0;
          state <= S_ARMED;
        end
        S_ARMED: if (wrong) begin
          grade_q <= GRADE_MISS;
          state <= S_REPORT;
        end else if (hit) begin
          grade_q <= offset <= PW ? GRADE_PERFECT : GRADE_GOOD;
          state <= S_REPORT;
        end else if (tick && win_cnt == WIN_END) begin
          grade_q <= GRADE_MISS;
          state <= S_REPORT;
        end else begin
          if (tick) win_cnt <= win_cnt + CW'(1);
          seen_edge <= seen_next;
        end
        S_REPORT: begin
          score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
          streak <= grade_q == GRADE_MISS ? '0 : (&streak ? streak : streak + STREAK_W'(1));
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_hit_judge.sv
// tb_note_hit_judge: directed checks of grading, timing and scoring
module tb_note_hit_judge;
  logic clk = 0, rst_n = 0, tick = 0, note_valid = 0;
  logic [4:0] btn_state = 0, note_mask = 0;
  logic note_ready, result_valid;
  logic [4:0] press_edge;
  logic [1:0] result_grade;
  logic [15:0] score;
  logic [7:0] streak;
  int checks = 0, errors = 0;

  note_hit_judge dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_state(btn_state),
    .note_valid(note_valid), .note_mask(note_mask), .note_ready(note_ready),
    .press_edge(press_edge), .result_valid(result_valid), .result_grade(result_grade),
    .score(score), .streak(streak)
  );

  always #5 clk = ~clk;

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task do_tick(input int n);
    repeat (n) begin
      tick = 1;
      cyc();
    end
    tick = 0;
  endtask

  task accept(input logic [4:0] m);
    note_valid = 1;
    note_mask = m;
    cyc();
    note_valid = 0;
  endtask

  task do_reset;
    rst_n = 0; tick = 0; btn_state = 0; note_valid = 0; note_mask = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task test_reset;
    rst_n = 0; btn_state = 5'b11111;
    cyc(); cyc();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", note_ready); end
    checks++; if (press_edge !== 5'b0) begin errors++; $display("FAIL reset_edge: got %b exp 00000", press_edge); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", result_valid); end
    checks++; if (result_grade !== 2'd0) begin errors++; $display("FAIL reset_grade: got %0d exp 0", result_grade); end
    checks++; if (score !== 16'd0 || streak !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d/%0d exp 0/0", score, streak); end
    btn_state = 0; rst_n = 1;
    cyc();
  endtask

  task test_perfect;
    do_reset();
    accept(5'b00001);
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL armed_ready: got %b exp 0", note_ready); end
    do_tick(8);
    btn_state = 5'b00001;
    cyc();
    checks++; if (press_edge !== 5'b00001 || result_valid !== 1'b0) begin errors++; $display("FAIL perfect_edge: got %b/%b exp 00001/0", press_edge, result_valid); end
    cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd2) begin errors++; $display("FAIL perfect_result: got %b/%0d exp 1/2", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd3 || streak !== 8'd1) begin errors++; $display("FAIL perfect_score: got %0d/%0d exp 3/1", score, streak); end
    checks++; if (result_valid !== 1'b0 || note_ready !== 1'b1) begin errors++; $display("FAIL perfect_idle: got %b/%b exp 0/1", result_valid, note_ready); end
    btn_state = 0; cyc();
  endtask

  task test_good_then_miss;
    do_reset();
    accept(5'b00001);
    do_tick(3);
    btn_state = 5'b00001;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd1) begin errors++; $display("FAIL good_result: got %b/%0d exp 1/1", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd1 || streak !== 8'd1) begin errors++; $display("FAIL good_score: got %0d/%0d exp 1/1", score, streak); end
    btn_state = 0; cyc();
    accept(5'b00001);
    do_tick(16);
    checks++; if (result_valid !== 1'b0 || note_ready !== 1'b0) begin errors++; $display("FAIL miss_early: got %b/%b exp 0/0", result_valid, note_ready); end
    do_tick(1);
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd0) begin errors++; $display("FAIL miss_result: got %b/%0d exp 1/0", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd1 || streak !== 8'd0) begin errors++; $display("FAIL miss_score: got %0d/%0d exp 1/0", score, streak); end
  endtask

  task test_chord;
    do_reset();
    accept(5'b00101);
    do_tick(7);
    btn_state = 5'b00001;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b0 || note_ready !== 1'b0) begin errors++; $display("FAIL chord_partial: got %b/%b exp 0/0", result_valid, note_ready); end
    do_tick(1);
    btn_state = 5'b00101;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd2) begin errors++; $display("FAIL chord_result: got %b/%0d exp 1/2", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd3 || result_valid !== 1'b0) begin errors++; $display("FAIL chord_score: got %0d/%b exp 3/0", score, result_valid); end
    btn_state = 0; cyc();
    do_reset();
    accept(5'b00101);
    do_tick(4);
    btn_state = 5'b00010;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd0) begin errors++; $display("FAIL wrong_lane: got %b/%0d exp 1/0", result_valid, result_grade); end
    btn_state = 0; cyc();
  endtask

  task test_wrong_and_complete;
    do_reset();
    accept(5'b00001);
    do_tick(8);
    btn_state = 5'b00011;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd0) begin errors++; $display("FAIL wrong_complete: got %b/%0d exp 1/0", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd0 || streak !== 8'd0) begin errors++; $display("FAIL wrong_complete_score: got %0d/%0d exp 0/0", score, streak); end
    btn_state = 0; cyc();
  endtask

  task test_held;
    do_reset();
    btn_state = 5'b00001;
    cyc(); cyc();
    accept(5'b00001);
    do_tick(4);
    checks++; if (result_valid !== 1'b0 || note_ready !== 1'b0) begin errors++; $display("FAIL held_no_hit: got %b/%b exp 0/0", result_valid, note_ready); end
    btn_state = 0; cyc();
    do_tick(5);
    btn_state = 5'b00001;
    cyc(); cyc();
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd2) begin errors++; $display("FAIL held_repress: got %b/%0d exp 1/2", result_valid, result_grade); end
    cyc();
    btn_state = 0; cyc();
  endtask

  task test_final_tick;
    do_reset();
    accept(5'b00001);
    do_tick(16);
    btn_state = 5'b00001;
    cyc();
    tick = 1; cyc(); tick = 0;
    checks++; if (result_valid !== 1'b1 || result_grade !== 2'd1) begin errors++; $display("FAIL final_tick_hit: got %b/%0d exp 1/1", result_valid, result_grade); end
    cyc();
    checks++; if (score !== 16'd1 || streak !== 8'd1) begin errors++; $display("FAIL final_tick_score: got %0d/%0d exp 1/1", score, streak); end
    btn_state = 0; cyc();
  endtask

  task test_back_to_back;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      accept(5'b00001);
      do_tick(8);
      btn_state = 5'b00001;
      cyc(); cyc();
      checks++; if (result_grade !== 2'd2 || result_valid !== 1'b1) begin errors++; $display("FAIL b2b_grade[%0d]: got %b/%0d exp 1/2", i, result_valid, result_grade); end
      btn_state = 0; cyc();
      if (i == 7) begin
        checks++; if (score !== 16'd24 || streak !== 8'd8) begin errors++; $display("FAIL b2b_eight: got %0d/%0d exp 24/8", score, streak); end
      end
    end
    checks++; if (score !== 16'd30 || streak !== 8'd9) begin errors++; $display("FAIL b2b_ninth: got %0d/%0d exp 30/9", score, streak); end
  endtask

  task test_reset_mid;
    accept(5'b00001);
    do_tick(4);
    rst_n = 0; cyc();
    checks++; if (result_valid !== 1'b0 || score !== 16'd0 || streak !== 8'd0 || note_ready !== 1'b1) begin errors++; $display("FAIL reset_mid: got %b/%0d/%0d/%b exp 0/0/0/1", result_valid, score, streak, note_ready); end
    rst_n = 1; cyc();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_after: got %b exp 0", result_valid); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_perfect();
    test_good_then_miss();
    test_chord();
    test_wrong_and_complete();
    test_held();
    test_final_tick();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_hit_judge.md
# note_hit_judge

Judges debounced fret-button presses against the note stream for one playing track. Sits directly downstream of the per-lane push-button debouncers, whose active-high `PB_state` outputs form `btn_state`, and upstream of the score/HUD display. Each accepted note opens a timing window. The block detects press edges, decides PERFECT/GOOD/MISS, and maintains a saturating score and streak with a streak multiplier.

## Interface
- `LANES`, 5, number of fret lanes
- `WINDOW`, 8, half-width of the hit window in ticks; the target is at `win_cnt == WINDOW`
- `PERFECT_W`, 2, maximum |offset| in ticks graded PERFECT
- `SCORE_W`, 16, score width
- `STREAK_W`, 8, streak width

- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `tick`  in  1  one-cycle timing pulse from the game timebase
- `btn_state`  in  LANES  debounced fret levels, 1 = held, synchronous to `clk`
- `note_valid`  in  1  next note offered
- `note_mask`  in  LANES  lanes forming the note (chord allowed; must be nonzero)
- `note_ready`  out  1  judge idle; the note is accepted when `note_valid && note_ready`
- `press_edge`  out  LANES  registered rising edges of `btn_state`
- `result_valid`  out  1  one-cycle pulse per judged note
- `result_grade`  out  2  0 MISS, 1 GOOD, 2 PERFECT (valid with `result_valid`)
- `score`  out  SCORE_W  running score, saturating
- `streak`  out  STREAK_W  consecutive hits, saturating

## Operation
- Edge detect:
  - `btn_q <= btn_state`; `press_edge <= btn_state & ~btn_q`.
  - Judging uses `press_edge` and `btn_q` only.
- States: IDLE, ARMED, REPORT.
- IDLE:
  - `note_ready = 1`.
  - On accept: latch `note_mask` into `mask_q`, clear `win_cnt` and `seen_edge`, go to ARMED.
- ARMED: `note_ready = 0`. Each cycle, conditions are evaluated in this priority order:
  1. `|(press_edge & ~mask_q)` → grade MISS, go to REPORT.
  2. `seen_edge_next && btn_q == mask_q` → hit, go to REPORT.
     - `seen_edge_next = seen_edge | |(press_edge & mask_q)`.
     - Grade PERFECT if `|win_cnt - WINDOW| <= PERFECT_W`, else GOOD.
  3. `tick && win_cnt == 2*WINDOW` → MISS, go to REPORT.
  4. Otherwise:
     - `tick` increments `win_cnt`;
     - `seen_edge <= seen_edge_next`.
- REPORT (exactly one cycle):
  - `result_valid = 1` with the registered grade.
  - Score and streak update, then go to IDLE.
- Multiplier:
  - `mult = min(1 + (streak >> 3), 4)`, computed from the pre-update streak.
- Score update:
  - PERFECT adds `3*mult`; GOOD adds `1*mult`; MISS adds 0.
  - Saturates at `2^SCORE_W - 1`; the adder is `SCORE_W+1` bits wide.
- Streak update: a hit adds 1, saturating at `2^STREAK_W - 1`; MISS clears it to 0.
- `win_cnt` width is `$clog2(2*WINDOW+1)`. The offset is computed as unsigned `|win_cnt - WINDOW|`.

## Timing
- Reset values:
  - state IDLE, `note_ready` 1, `press_edge` 0, `result_valid` 0, `result_grade` 0;
  - `score` 0, `streak` 0, `btn_q` 0, `win_cnt` 0.
- Asserting `rst_n` low mid-window abandons the note. No result is emitted and score/streak clear.
- A `btn_state` rise at cycle n gives `press_edge` high at n+1. A hit is decided at n+1, `result_valid` pulses at n+2, and `score`/`streak` are updated from cycle n+3.
- A note accepted at cycle a can be judged no earlier than a+1. `note_ready` returns 1 the cycle after REPORT; the minimum accept-to-accept interval is 3 cycles.
- A hit and the final `tick` in the same cycle → hit wins.
- A wrong-lane edge and the completing edge in the same cycle → MISS.
- Buttons held before acceptance do not count: a hit requires a rising edge on a mask lane inside ARMED.
- `note_valid` is ignored outside IDLE. The upstream holds the note until accepted.

## Structure
- Package `guitar_pkg` holds:
  - `LANES_DEF`;
  - `typedef enum logic [1:0] {GRADE_MISS, GRADE_GOOD, GRADE_PERFECT} grade_e`;
  - the judge state enum;
  - the base-point constants 1 and 3;
  - the multiplier cap 4.
- One sub-module, `lane_edge_detect` (parameter `LANES`), produces `btn_q` and `press_edge`. The FSM, window counter and score logic live in the top.

## Test plan
- Reset, accept mask `00001`, 8 ticks, raise lane 0 → `result_grade`=2, `score`=3, `streak`=1; `result_valid` 2 cycles after the rise.
- Accept `00001`, raise lane 0 after 3 ticks (offset 5) → GOOD, `score`=1.
- Accept `00001`, no press for 17 ticks → MISS on the 17th tick, `streak`=0, `score` unchanged.
- Accept `00101`, raise lane 0 after 7 ticks and lane 2 after 8 ticks → single PERFECT at the lane-2 edge. Alternate case: lane 1 raised during the window → immediate MISS.
- Accept `00001` while lane 0 is already held → no hit until release and re-press; re-press after 9 ticks → PERFECT.
- Eight consecutive PERFECTs (`score`=24, `streak`=8), then a ninth → `score`=30. Reset asserted mid-window → `score`=0, no `result_valid`.
